// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues one icache request at a time, assembles
// FETCH_BYTES-wide beats into 32-bit words and queues {instruction, PC} for the decoder.
module fetch_queue #(
  parameter int unsigned         ADDR_W      = 32,
  parameter int unsigned         DEPTH_LOG2  = 3,
  parameter int unsigned         FETCH_BYTES = 4,
  parameter logic [ADDR_W-1:0]   RESET_PC    = '0
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     flush_in,
  input  logic [ADDR_W-1:0]        flush_pc_in,
  output logic                     icache_req_out,
  output logic [ADDR_W-1:0]        icache_addr_out,
  input  logic                     icache_valid_in,
  input  logic [8*FETCH_BYTES-1:0] icache_data_in,
  output logic                     dec_valid_out,
  input  logic                     dec_ready_in,
  output logic [31:0]              dec_ins_out,
  output logic [ADDR_W-1:0]        dec_pc_out,
  output logic [DEPTH_LOG2:0]      count_out
);

  localparam int unsigned       Depth    = 1 << DEPTH_LOG2;
  localparam int unsigned       Beats    = 4 / FETCH_BYTES;
  localparam int unsigned       BeatW    = 8 * FETCH_BYTES;
  localparam logic [1:0]        LastBeat = 2'(Beats - 1);
  localparam logic [ADDR_W-1:0] Step     = ADDR_W'(FETCH_BYTES);
  localparam logic [DEPTH_LOG2:0] Full   = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

  state_e                  state;
  logic [ADDR_W-1:0]       fpc;
  logic [ADDR_W-1:0]       word_pc;
  logic [1:0]              beat;
  logic [31:0]             asm_word;
  logic [DEPTH_LOG2-1:0]   wptr;
  logic [DEPTH_LOG2-1:0]   rptr;
  logic [DEPTH_LOG2:0]     count;

  logic [31:0]             mem_ins [Depth];
  logic [ADDR_W-1:0]       mem_pc  [Depth];

  logic                    full;
  logic                    take;
  logic                    push;
  logic                    pop;
  logic [31:0]             asm_next;
  logic [ADDR_W-1:0]       push_pc;
  logic                    unused_flush_bits;

  // Redirect targets are word aligned; the low PC bits are dropped.
  assign unused_flush_bits = ^flush_pc_in[1:0];

  assign full = (count == Full);

  // Reset gates the request so nothing leaks out while the FSM is held in IDLE.
  assign icache_req_out  = rst_in & rdy_in & ~flush_in & (state == StIdle) & ~full;
  assign icache_addr_out = icache_req_out ? fpc : '0;

  assign take = rdy_in & ~flush_in & (state == StWait) & icache_valid_in;
  assign push = take & (beat == LastBeat);
  assign pop  = rdy_in & ~flush_in & dec_valid_out & dec_ready_in;

  always_comb begin
    asm_next = asm_word;
    asm_next[int'(beat) * BeatW +: BeatW] = icache_data_in;
  end

  assign push_pc = (beat == 2'd0) ? fpc : word_pc;

  // Fetch FSM, fetch PC and beat assembly.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= StIdle;
      fpc      <= RESET_PC;
      word_pc  <= '0;
      beat     <= 2'd0;
      asm_word <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        fpc  <= {flush_pc_in[ADDR_W-1:2], 2'b00};
        beat <= 2'd0;
        case (state)
          StWait:  state <= icache_valid_in ? StIdle : StDrop;
          // The stale response the DROP state waits for is arriving right now.
          StDrop:  if (icache_valid_in) state <= StIdle;
          default: state <= state;
        endcase
      end else begin
        unique case (state)
          StIdle: begin
            if (icache_req_out) state <= StWait;
          end
          StWait: begin
            if (icache_valid_in) begin
              state    <= StIdle;
              fpc      <= fpc + Step;
              asm_word <= asm_next;
              if (beat == 2'd0) word_pc <= fpc;
              beat     <= (beat == LastBeat) ? 2'd0 : beat + 2'd1;
            end
          end
          StDrop: begin
            if (icache_valid_in) state <= StIdle;
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

  // Queue pointers and occupancy; flush wins over any push or pop.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
        unique case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_ins[wptr] <= asm_next;
      mem_pc[wptr]  <= push_pc;
    end
  end

  assign dec_valid_out = (count != '0);
  assign dec_ins_out   = mem_ins[rptr];
  assign dec_pc_out    = mem_pc[rptr];
  assign count_out     = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus a randomized run against a queue-based model.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        dec_ready = 1'b0;

  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_valid = 1'b0;
  logic [31:0] ic_data = '0;
  logic        dv;
  logic [31:0] dins;
  logic [31:0] dpc;
  logic [3:0]  cnt;

  logic        ic_req1;
  logic [31:0] ic_addr1;
  logic        ic_valid1 = 1'b0;
  logic [7:0]  ic_data1 = '0;
  logic        dv1;
  logic [31:0] dins1;
  logic [31:0] dpc1;
  logic [3:0]  cnt1;

  int total = 0;
  int bad = 0;

  logic        auto_en = 1'b0;
  logic        auto_hold = 1'b0;
  logic        auto_busy = 1'b0;
  logic [31:0] auto_addr = '0;

  fetch_queue dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .flush_in(flush), .flush_pc_in(flush_pc),
    .icache_req_out(ic_req), .icache_addr_out(ic_addr), .icache_valid_in(ic_valid),
    .icache_data_in(ic_data), .dec_valid_out(dv), .dec_ready_in(dec_ready),
    .dec_ins_out(dins), .dec_pc_out(dpc), .count_out(cnt)
  );

  fetch_queue #(.FETCH_BYTES(1)) dut1 (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .flush_in(flush), .flush_pc_in(flush_pc),
    .icache_req_out(ic_req1), .icache_addr_out(ic_addr1), .icache_valid_in(ic_valid1),
    .icache_data_in(ic_data1), .dec_valid_out(dv1), .dec_ready_in(dec_ready),
    .dec_ins_out(dins1), .dec_pc_out(dpc1), .count_out(cnt1)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] h;
    h = a * 32'h9E3779B1;
    h = h ^ (h >> 15);
    return h[7:0];
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {byte_at(a + 32'd3), byte_at(a + 32'd2), byte_at(a + 32'd1), byte_at(a)};
  endfunction

  // Icache stand-in: answers each request one cycle later unless held.
  initial begin : icache_bg
    logic        got;
    logic        cons;
    logic [31:0] a;
    forever begin
      @(posedge clk);
      got  = ic_req;
      a    = ic_addr;
      cons = ic_valid && rdy;
      @(negedge clk);
      #2;
      if (!rst_n) begin
        auto_busy = 1'b0;
      end else if (auto_en) begin
        if (cons) auto_busy = 1'b0;
        if (got) begin
          auto_busy = 1'b1;
          auto_addr = a;
        end
      end
      if (auto_en) begin
        ic_valid = auto_busy && !auto_hold;
        ic_data  = ic_valid ? word_at(auto_addr) : 32'hDEAD_BEEF;
      end
    end
  end

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; dec_ready = 1'b0;
    auto_en = 1'b0; auto_hold = 1'b0; ic_valid = 1'b0; ic_valid1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset;
    auto_en = 1'b1; dec_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    total++; if (dv !== 1'b0) begin bad++; $display("FAIL reset.dec_valid got=%b want=0", dv); end
    total++; if (ic_req !== 1'b0) begin bad++; $display("FAIL reset.req got=%b want=0", ic_req); end
    total++; if (ic_addr !== 32'h0) begin bad++; $display("FAIL reset.addr got=%h want=0", ic_addr); end
    total++; if (cnt !== 4'd0) begin bad++; $display("FAIL reset.count got=%0d want=0", cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    total++; if (ic_req !== 1'b1 || ic_addr !== 32'hC) begin
      bad++; $display("FAIL reset.pre_req got=%b/%h want=1/0000000c", ic_req, ic_addr);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (ic_req !== 1'b0 || cnt !== 4'd0 || dv !== 1'b0) begin
      bad++; $display("FAIL reset.mid_wait req=%b cnt=%0d dv=%b want 0/0/0", ic_req, cnt, dv);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (ic_req !== 1'b1 || ic_addr !== 32'h0) begin
      bad++; $display("FAIL reset.first_req got=%b/%h want=1/00000000", ic_req, ic_addr);
    end
  endtask

  task automatic test_fetch_seq;
    logic [31:0] ea;
    logic [31:0] ep;
    logic        exp_req;
    logic        exp_dv;
    do_reset;
    auto_en = 1'b1; dec_ready = 1'b1; ea = 0; ep = 0;
    for (int k = 0; k < 14; k++) begin
      #1;
      exp_req = (k % 2 == 0);
      exp_dv  = (k >= 2) && (k % 2 == 0);
      total++; if (ic_req !== exp_req) begin
        bad++; $display("FAIL seq.req k=%0d got=%b want=%b", k, ic_req, exp_req);
      end
      if (exp_req) begin
        total++; if (ic_addr !== ea) begin
          bad++; $display("FAIL seq.addr k=%0d got=%h want=%h", k, ic_addr, ea);
        end
        ea += 4;
      end
      total++; if (dv !== exp_dv) begin
        bad++; $display("FAIL seq.dec_valid k=%0d got=%b want=%b", k, dv, exp_dv);
      end
      if (exp_dv) begin
        total++; if (dpc !== ep || dins !== word_at(ep)) begin
          bad++; $display("FAIL seq.head k=%0d got=%h/%h want=%h/%h", k, dpc, dins, ep, word_at(ep));
        end
        ep += 4;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_full;
    logic        exp_req;
    int          exp_cnt;
    int          nreq;
    do_reset;
    auto_en = 1'b1; dec_ready = 1'b0;
    for (int k = 0; k < 24; k++) begin
      #1;
      exp_req = (k % 2 == 0) && (k < 16);
      exp_cnt = (k / 2 > 8) ? 8 : k / 2;
      total++; if (ic_req !== exp_req) begin
        bad++; $display("FAIL full.req k=%0d got=%b want=%b", k, ic_req, exp_req);
      end
      total++; if (cnt !== 4'(exp_cnt)) begin
        bad++; $display("FAIL full.count k=%0d got=%0d want=%0d", k, cnt, exp_cnt);
      end
      if (exp_req) begin
        total++; if (ic_addr !== 32'(4 * (k / 2))) begin
          bad++; $display("FAIL full.addr k=%0d got=%h want=%h", k, ic_addr, 4 * (k / 2));
        end
      end
      @(negedge clk);
    end
    dec_ready = 1'b1;
    #1;
    total++; if (dv !== 1'b1 || dpc !== 32'h0 || dins !== word_at(0)) begin
      bad++; $display("FAIL full.head got=%b/%h/%h want=1/0/%h", dv, dpc, dins, word_at(0));
    end
    @(negedge clk);
    dec_ready = 1'b0;
    nreq = 0;
    for (int k = 25; k < 32; k++) begin
      #1;
      if (k == 25) begin
        total++; if (cnt !== 4'd7) begin bad++; $display("FAIL full.after_pop got=%0d want=7", cnt); end
      end
      if (ic_req === 1'b1) begin
        nreq++;
        total++; if (ic_addr !== 32'h20) begin
          bad++; $display("FAIL full.refill_addr got=%h want=00000020", ic_addr);
        end
      end
      @(negedge clk);
    end
    total++; if (nreq != 1) begin bad++; $display("FAIL full.refill_reqs got=%0d want=1", nreq); end
    total++; if (cnt !== 4'd8) begin bad++; $display("FAIL full.refilled got=%0d want=8", cnt); end
  endtask

  task automatic test_flush;
    do_reset;
    auto_en = 1'b1; dec_ready = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    total++; if (cnt !== 4'd2 || ic_req !== 1'b1 || ic_addr !== 32'h8) begin
      bad++; $display("FAIL flush.setup cnt=%0d req=%b addr=%h want 2/1/00000008", cnt, ic_req, ic_addr);
    end
    @(negedge clk);
    auto_hold = 1'b1; flush = 1'b1; flush_pc = 32'h1002;
    #1;
    total++; if (ic_req !== 1'b0) begin bad++; $display("FAIL flush.req_in_flush got=%b want=0", ic_req); end
    @(negedge clk);
    auto_hold = 1'b0; flush = 1'b0;
    #1;
    total++; if (cnt !== 4'd0 || dv !== 1'b0 || ic_req !== 1'b0) begin
      bad++; $display("FAIL flush.cleared cnt=%0d dv=%b req=%b want 0/0/0", cnt, dv, ic_req);
    end
    @(negedge clk);
    #1;
    total++; if (cnt !== 4'd0) begin bad++; $display("FAIL flush.stale_dropped got=%0d want=0", cnt); end
    total++; if (ic_req !== 1'b1 || ic_addr !== 32'h1000) begin
      bad++; $display("FAIL flush.redirect got=%b/%h want=1/00001000", ic_req, ic_addr);
    end
    repeat (2) @(negedge clk);
    #1;
    total++; if (cnt !== 4'd1 || dpc !== 32'h1000 || dins !== word_at(32'h1000)) begin
      bad++; $display("FAIL flush.first_entry cnt=%0d pc=%h ins=%h want 1/00001000/%h", cnt, dpc,
                      dins, word_at(32'h1000));
    end
  endtask

  task automatic test_stall;
    do_reset;
    auto_en = 1'b1; dec_ready = 1'b0;
    repeat (3) @(negedge clk);
    rdy = 1'b0; auto_hold = 1'b1; dec_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (ic_req !== 1'b0 || ic_addr !== 32'h0 || cnt !== 4'd1 || dv !== 1'b1 ||
                   dpc !== 32'h0 || dins !== word_at(0)) begin
        bad++; $display("FAIL stall.frozen k=%0d req=%b addr=%h cnt=%0d dv=%b pc=%h ins=%h", k,
                        ic_req, ic_addr, cnt, dv, dpc, dins);
      end
      @(negedge clk);
    end
    rdy = 1'b1; auto_hold = 1'b0; dec_ready = 1'b0;
    #1;
    total++; if (ic_req !== 1'b0 || cnt !== 4'd1) begin
      bad++; $display("FAIL stall.resume_wait req=%b cnt=%0d want 0/1", ic_req, cnt);
    end
    @(negedge clk);
    #1;
    total++; if (cnt !== 4'd2 || ic_req !== 1'b1 || ic_addr !== 32'h8) begin
      bad++; $display("FAIL stall.resumed cnt=%0d req=%b addr=%h want 2/1/00000008", cnt, ic_req,
                      ic_addr);
    end
  endtask

  task automatic test_push_pop;
    do_reset;
    auto_en = 1'b1; dec_ready = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    total++; if (cnt !== 4'd3 || ic_req !== 1'b1 || ic_addr !== 32'hC) begin
      bad++; $display("FAIL pushpop.setup cnt=%0d req=%b addr=%h want 3/1/0000000c", cnt, ic_req,
                      ic_addr);
    end
    @(negedge clk);
    dec_ready = 1'b1;
    #1;
    total++; if (dv !== 1'b1 || dpc !== 32'h0) begin
      bad++; $display("FAIL pushpop.head dv=%b pc=%h want 1/00000000", dv, dpc);
    end
    @(negedge clk);
    dec_ready = 1'b0;
    #1;
    total++; if (cnt !== 4'd3 || dpc !== 32'h4 || dins !== word_at(4)) begin
      bad++; $display("FAIL pushpop.same_cycle cnt=%0d pc=%h ins=%h want 3/00000004/%h", cnt, dpc,
                      dins, word_at(4));
    end
  endtask

  task automatic test_fb1;
    logic [7:0] b [4];
    b[0] = 8'h13; b[1] = 8'h05; b[2] = 8'h10; b[3] = 8'h00;
    do_reset;
    dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ic_valid1 = 1'b0;
      #1;
      total++; if (ic_req1 !== 1'b1 || ic_addr1 !== 32'(i) || cnt1 !== 4'd0) begin
        bad++; $display("FAIL fb1.req i=%0d req=%b addr=%h cnt=%0d want 1/%h/0", i, ic_req1,
                        ic_addr1, cnt1, i);
      end
      @(negedge clk);
      ic_valid1 = 1'b1; ic_data1 = b[i];
      #1;
      total++; if (ic_req1 !== 1'b0) begin bad++; $display("FAIL fb1.no_req i=%0d got=%b want=0", i, ic_req1); end
      @(negedge clk);
    end
    ic_valid1 = 1'b0;
    #1;
    total++; if (dv1 !== 1'b1 || dins1 !== 32'h00100513 || dpc1 !== 32'h0 || cnt1 !== 4'd1) begin
      bad++; $display("FAIL fb1.entry dv=%b ins=%h pc=%h cnt=%0d want 1/00100513/0/1", dv1, dins1,
                      dpc1, cnt1);
    end
    total++; if (ic_req1 !== 1'b1 || ic_addr1 !== 32'h4) begin
      bad++; $display("FAIL fb1.next_addr got=%b/%h want=1/00000004", ic_req1, ic_addr1);
    end
  endtask

  task automatic test_random;
    logic [63:0] mq [$];
    logic [31:0] fpc;
    logic [31:0] rq_addr;
    logic        exp_req;
    int          pend;
    int          timer;
    do_reset;
    auto_en = 1'b0; fpc = 0; pend = 0; timer = 0; rq_addr = 0;
    for (int c = 0; c < 4000; c++) begin
      rdy       = ($urandom_range(0, 9) != 0);
      dec_ready = ((c % 800) < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      ic_valid  = rdy && (pend != 0) && (timer == 0);
      ic_data   = ic_valid ? word_at(rq_addr) : $urandom;
      flush     = ($urandom_range(0, 24) == 0) && !(pend == 2 && ic_valid);
      flush_pc  = $urandom;
      #1;
      exp_req = rdy && !flush && (pend == 0) && (mq.size() < 8);
      total++; if (ic_req !== exp_req) begin
        bad++; $display("FAIL rand.req c=%0d got=%b want=%b", c, ic_req, exp_req);
      end
      if (exp_req) begin
        total++; if (ic_addr !== fpc) begin
          bad++; $display("FAIL rand.addr c=%0d got=%h want=%h", c, ic_addr, fpc);
        end
      end
      total++; if (cnt !== 4'(mq.size()) || dv !== (mq.size() != 0)) begin
        bad++; $display("FAIL rand.count c=%0d got=%0d/%b want=%0d", c, cnt, dv, mq.size());
      end
      if (mq.size() != 0) begin
        total++; if ({dins, dpc} !== mq[0]) begin
          bad++; $display("FAIL rand.head c=%0d got=%h/%h want=%h", c, dins, dpc, mq[0]);
        end
      end
      if (rdy) begin
        if (pend != 0 && !ic_valid && timer > 0) timer--;
        if (flush) begin
          mq.delete();
          fpc = {flush_pc[31:2], 2'b00};
          if (pend == 1) pend = ic_valid ? 0 : 2;
        end else begin
          if (mq.size() != 0 && dec_ready) void'(mq.pop_front());
          if (ic_valid) begin
            if (pend == 1) begin
              mq.push_back({word_at(fpc), fpc});
              fpc += 4;
            end
            pend = 0;
          end
          if (exp_req) begin
            pend = 1;
            rq_addr = ic_addr;
            timer = $urandom_range(0, 2);
          end
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_fetch_seq;
    test_full;
    test_flush;
    test_stall;
    test_push_pop;
    test_fb1;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
